// File: rtl/vga_fb_scanout.sv
// VGA scan-out reader for the 160x120x8bpp pixel buffer, 640x480@60 timing from the system clock.
// Stage 0 issues the buffer read from the raster counters, stage 1 drives the VGA pins one pixel later.
module vga_fb_scanout #(
   parameter int PIX_DIV    = 2,
   parameter int H_VIS      = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VIS      = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SCALE_LOG2 = 2,
   parameter bit SYNC_POL   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_en,
   output logic [7:0] fb_rd_x,
   output logic [6:0] fb_rd_y,
   output logic       fb_rd_en,
   input  logic [7:0] fb_rd_data,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic [7:0] vga_rgb,
   output logic       frame_start
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [9:0] H_VIS_C = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C = 10'(V_VIS);
   localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] H_SS    = 10'(H_VIS + H_FP);
   localparam logic [9:0] H_SE    = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] V_SS    = 10'(V_VIS + V_FP);
   localparam logic [9:0] V_SE    = 10'(V_VIS + V_FP + V_SYNC);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h, r_v, r_h_d, r_v_d;
   logic             r_s0_vld, r_rd_en, r_rd_en_q, r_fs;
   logic [7:0]       r_rd_x, r_hold, r_rgb;
   logic [6:0]       r_rd_y;
   logic             r_hs, r_vs, r_blank_n;

   logic             w_pix_en, w_run, w_adv, w_issue, w_frm0;
   logic             w_h_last, w_v_last, w_vis1, w_hs_act, w_vs_act;
   logic [7:0]       w_pix_data;

   assign w_pix_en = (r_div == '0);
   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              r_div <= '0;
      else if (r_div == DIV_W'(PIX_DIV - 1)) r_div <= '0;
      else                                   r_div <= r_div + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // scan_en only matters at the last pixel of a frame, so a frame is never cut short
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pix_en && scan_en) w_state_nxt = S_RUN;
         S_RUN:   if (w_pix_en && w_h_last && w_v_last && !scan_en) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_pix_en) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_run      = (r_state == S_RUN);
      w_adv      = w_pix_en && w_run;
      w_issue    = w_adv && (r_h < H_VIS_C) && (r_v < V_VIS_C);
      w_frm0     = w_adv && (r_h == '0) && (r_v == '0);
      w_vis1     = r_s0_vld && (r_h_d < H_VIS_C) && (r_v_d < V_VIS_C);
      w_hs_act   = r_s0_vld && (r_h_d >= H_SS) && (r_h_d < H_SE);
      w_vs_act   = r_s0_vld && (r_v_d >= V_SS) && (r_v_d < V_SE);
      w_pix_data = r_rd_en_q ? fb_rd_data : r_hold;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (!w_run) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_pix_en) begin
         if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   // stage 0: read strobe and frame marker are single-clk pulses at the issuing pix_en
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_en   <= 1'b0;
         r_rd_en_q <= 1'b0;
         r_fs      <= 1'b0;
         r_rd_x    <= '0;
         r_rd_y    <= '0;
         r_hold    <= '0;
         r_s0_vld  <= 1'b0;
         r_h_d     <= '0;
         r_v_d     <= '0;
      end else begin
         r_rd_en   <= w_issue;
         r_rd_en_q <= r_rd_en;
         r_fs      <= w_frm0;
         if (w_issue) begin
            r_rd_x <= 8'(r_h >> SCALE_LOG2);
            r_rd_y <= 7'(r_v >> SCALE_LOG2);
         end
         if (r_rd_en_q) r_hold <= fb_rd_data;
         if (w_pix_en) begin
            r_s0_vld <= w_run;
            r_h_d    <= r_h;
            r_v_d    <= r_v;
         end
      end
   end

   // stage 1: sync, blank and colour all come from the same delayed position
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hs      <= !SYNC_POL;
         r_vs      <= !SYNC_POL;
         r_blank_n <= 1'b0;
         r_rgb     <= '0;
      end else if (w_pix_en) begin
         r_hs      <= w_hs_act ? SYNC_POL : !SYNC_POL;
         r_vs      <= w_vs_act ? SYNC_POL : !SYNC_POL;
         r_blank_n <= w_vis1;
         r_rgb     <= w_vis1 ? w_pix_data : 8'h00;
      end
   end

   assign fb_rd_x     = r_rd_x;
   assign fb_rd_y     = r_rd_y;
   assign fb_rd_en    = r_rd_en;
   assign vga_hs      = r_hs;
   assign vga_vs      = r_vs;
   assign vga_blank_n = r_blank_n;
   assign vga_rgb     = r_rgb;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout on a shrunken raster: a frame-position model predicts every pin each clk.
module tb_vga_fb_scanout;
   localparam int PD = 3, HV = 32, HF = 4, HS = 8, HB = 4;
   localparam int VV = 16, VF = 2, VS = 2, VB = 3, SL = 2;
   localparam bit POL = 1'b0;
   localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB, TOT = HT * VT;

   logic clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0;
   logic [7:0] fb_rd_x, fb_rd_data = 8'h00, vga_rgb;
   logic [6:0] fb_rd_y;
   logic fb_rd_en, vga_hs, vga_vs, vga_blank_n, frame_start;

   always #5 clk = ~clk;

   vga_fb_scanout #(
      .PIX_DIV(PD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE_LOG2(SL), .SYNC_POL(POL)
   ) dut (
      .clk(clk), .rst(rst_n), .scan_en(scan_en),
      .fb_rd_x(fb_rd_x), .fb_rd_y(fb_rd_y), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_rgb(vga_rgb),
      .frame_start(frame_start)
   );

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
   endtask

   // buffer: 1-clk latency, garbage on every other clk so the DUT must hold the sample
   logic [7:0] mem [0:7][0:3];
   bit pat;
   always @(posedge clk)
      fb_rd_data <= fb_rd_en ? mem[fb_rd_x[2:0]][fb_rd_y[1:0]] : 8'($urandom);

   int rel = 0;
   bit pix_edge = 0, se_q = 0;
   always @(posedge clk) begin
      se_q <= scan_en;
      if (!rst_n) begin
         rel <= 0;
         pix_edge <= 0;
      end else begin
         pix_edge <= (rel % PD == 0);
         rel <= rel + 1;
      end
   end

   function automatic bit vis(input int q);
      return (q % HT < HV) && (q / HT < VV);
   endfunction

   // model: mode 0 idle, 1 scanning frame position p, 2 draining
   int mode = 0, p = 0, cur = -1, prv = -1, lx = 0, ly = 0, cip = 0, h, v;
   bit b2b = 0, have_fs = 0;
   int cyc = 0, fs_cyc = 0, rd_cnt = 0, hs_falls = 0, xmax = 0, ymax = 0;
   logic hs_prev = 1'b1;
   int e_en, e_fs, e_hs, e_vs, e_bl, e_rgb;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         mode = 0; p = 0; cur = -1; prv = -1; lx = 0; ly = 0; cip = 0;
         b2b = 0; have_fs = 0; hs_prev = 1'b1;
      end else if (pix_edge) begin
         prv = cur;
         case (mode)
            0: begin cur = -1; if (se_q) begin mode = 1; p = 0; b2b = 0; end end
            1: begin
               cur = p;
               if (p == TOT - 1) begin
                  if (se_q) begin p = 0; b2b = 1; end
                  else mode = 2;
               end else p++;
            end
            default: begin cur = -1; mode = 0; end
         endcase
         if (cur >= 0 && vis(cur)) begin
            lx = (cur % HT) >> SL;
            ly = (cur / HT) >> SL;
         end
         cip = 0;
      end else cip++;

      e_en = (rst_n && cip == 0 && cur >= 0 && vis(cur));
      e_fs = (rst_n && cip == 0 && cur == 0);
      e_hs = !POL; e_vs = !POL; e_bl = 0; e_rgb = 0;
      if (prv >= 0) begin
         h = prv % HT; v = prv / HT;
         if (h >= HV + HF && h < HV + HF + HS) e_hs = POL;
         if (v >= VV + VF && v < VV + VF + VS) e_vs = POL;
         if (vis(prv)) begin e_bl = 1; e_rgb = mem[h >> SL][v >> SL]; end
         if (pat && e_bl == 1 && v == 5 && h < 8) chk("line5_rgb", vga_rgb, (h < 4) ? 8'h01 : 8'h09);
      end
      chk("rd_en", fb_rd_en, e_en);
      chk("rd_x", fb_rd_x, lx);
      chk("rd_y", fb_rd_y, ly);
      chk("frame_start", frame_start, e_fs);
      chk("hs", vga_hs, e_hs);
      chk("vs", vga_vs, e_vs);
      chk("blank_n", vga_blank_n, e_bl);
      chk("rgb", vga_rgb, e_rgb);

      if (rst_n) begin
         if (frame_start) begin
            if (have_fs) begin
               chk("rd_per_frame", rd_cnt, HV * VV);
               chk("hs_per_frame", hs_falls, VT);
               chk("rd_x_max", xmax, (HV >> SL) - 1);
               chk("rd_y_max", ymax, (VV >> SL) - 1);
               if (b2b) chk("frame_period", cyc - fs_cyc, TOT * PD);
            end
            have_fs = 1; fs_cyc = cyc; rd_cnt = 0; hs_falls = 0; xmax = 0; ymax = 0;
         end
         if (fb_rd_en) begin
            rd_cnt++;
            if (int'(fb_rd_x) > xmax) xmax = fb_rd_x;
            if (int'(fb_rd_y) > ymax) ymax = fb_rd_y;
         end
         if (hs_prev && !vga_hs) hs_falls++;
         hs_prev = vga_hs;
      end
   end

   task automatic chk_idle_pins(input string tag);
      chk({tag, "_hs"}, vga_hs, !POL);
      chk({tag, "_vs"}, vga_vs, !POL);
      chk({tag, "_blank"}, vga_blank_n, 0);
      chk({tag, "_rgb"}, vga_rgb, 0);
   endtask

   initial begin
      bit seen;
      int n, drop_y, rd_seen;
      pat = 1;
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 4; y++) mem[x][y] = {5'(x), 3'(y)};

      // reset held, then idle with scan_en low
      repeat (5) @(negedge clk);
      chk_idle_pins("rst");
      #2 rst_n = 1'b1;
      rd_seen = 0;
      repeat (1000) begin @(negedge clk); if (fb_rd_en) rd_seen++; end
      chk("idle_rd_en", rd_seen, 0);
      chk_idle_pins("idle");

      // continuous scan over several frames
      scan_en = 1'b1;
      repeat (TOT * PD * 5 / 2) @(negedge clk);

      // drop scan_en partway down a frame
      drop_y = $urandom_range(1, 3);
      seen = 0;
      for (int i = 0; i < TOT * PD * 2 && !seen; i++) begin
         @(negedge clk);
         if (fb_rd_en && fb_rd_y == 7'(drop_y)) seen = 1;
      end
      chk("wait_drop_line", seen, 1);
      scan_en = 1'b0;
      repeat (TOT * PD + 30) @(negedge clk);
      rd_seen = 0;
      repeat (300) begin @(negedge clk); if (fb_rd_en) rd_seen++; end
      chk("drained_rd_en", rd_seen, 0);
      chk_idle_pins("drained");

      // asynchronous reset mid-line
      scan_en = 1'b1;
      seen = 0;
      for (int i = 0; i < TOT * PD * 2 && !seen; i++) begin
         @(negedge clk);
         if (fb_rd_en && fb_rd_y == 7'd2 && fb_rd_x == 8'd5) seen = 1;
      end
      chk("wait_mid_line", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_idle_pins("async_rst");
      chk("async_rst_rd_en", fb_rd_en, 0);
      chk("async_rst_x", fb_rd_x, 0);
      chk("async_rst_y", fb_rd_y, 0);
      chk("async_rst_fs", frame_start, 0);
      pat = 0;
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 4; y++) mem[x][y] = 8'($urandom);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
      n = 0;
      seen = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (frame_start) begin seen = 1; n = i; end
      end
      chk("fs_after_rst_clks", n, PD + 1);

      // random scan_en activity
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 1499) == 0) scan_en = ~scan_en;
      end
      scan_en = 1'b0;
      repeat (TOT * PD + 30) @(negedge clk);
      chk_idle_pins("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
